// File: rtl/axi4_defs.sv
// axi4_defs: shared AXI4 encodings and fetch FSM state type.
// Imported by axi4_fetch_fifo and axi4_burst_fetch.
package axi4_defs;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam int         PAGE_BYTES  = 4096;
  localparam int         PAGE_WORDS  = PAGE_BYTES / 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/axi4_fetch_fifo.sv
// axi4_fetch_fifo: synchronous first-word-fall-through FIFO.
// Head word is visible on rd_data_o whenever empty_o is low.
module axi4_fetch_fifo
  import axi4_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr     = wr_en_i && (cnt_q != CW'(DEPTH));
  assign do_rd     = rd_en_i && (cnt_q != '0);
  assign rd_data_o = mem[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/axi4_burst_fetch.sv
// axi4_burst_fetch: credit-limited AXI4 INCR read fetcher to word stream.
// Define AXI_FETCH_4K_SPLIT_EN to split bursts at 4KB page boundaries.
module axi4_burst_fetch
  import axi4_defs::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         BURST_LEN  = 16,
  parameter int         FIFO_DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [23:0] cmd_len_i,
  output logic        cmd_ready_o,
  output logic        busy_o,
  output logic        error_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic        outport_last_o,
  input  logic        outport_ready_i,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [23:0] remaining_q;
  logic [23:0] out_cnt_q;
  logic [CW-1:0] alloc_q;
  logic [CW-1:0] free_w;
  logic [8:0]  beats_q;
  logic [8:0]  beats_c;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        error_q;
  logic        cmd_acc;
  logic        ar_hs;
  logic        r_wr;
  logic        pop;
  logic        issue;
  logic        page_cross;
  logic        fifo_empty;
  logic        fifo_full;
  logic [CW-1:0] fifo_cnt;
  logic        unused_ok;

  assign cmd_acc = (state_q == ST_IDLE) && cmd_valid_i;
  assign ar_hs   = arvalid_q && outport_arready_i;
  assign r_wr    = outport_rvalid_i && outport_rready_o;
  assign pop     = outport_valid_o && outport_ready_i;
  assign free_w  = CW'(FIFO_DEPTH) - alloc_q;
  assign issue   = (state_q == ST_REQ) && !arvalid_q &&
                   (remaining_q != '0) &&
                   (32'(free_w) >= 32'(beats_c));

`ifdef AXI_FETCH_4K_SPLIT_EN
  logic [10:0] words_4k;
  assign words_4k   = 11'(PAGE_WORDS) - {1'b0, addr_q[11:2]};
  assign page_cross = 1'b0;
`else
  assign page_cross =
    ({1'b0, addr_q[11:2]} + 11'(beats_c)) > 11'(PAGE_WORDS);
`endif

  // Next burst size from burst cap, remaining words and page room
  always_comb begin
    beats_c = 9'(BURST_LEN);
    if (remaining_q < 24'(BURST_LEN)) beats_c = remaining_q[8:0];
`ifdef AXI_FETCH_4K_SPLIT_EN
    if (words_4k < 11'(beats_c)) beats_c = words_4k[8:0];
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (cmd_acc && cmd_len_i != '0) state_d = ST_REQ;
      ST_REQ:
        if (ar_hs && remaining_q == 24'(beats_q)) state_d = ST_DRAIN;
      ST_DRAIN:
        if (pop && out_cnt_q == 24'd1) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Address, credit, AR channel and error tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_cnt_q   <= '0;
      alloc_q     <= '0;
      beats_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      if (cmd_acc) begin
        addr_q      <= {cmd_addr_i[31:2], 2'b00};
        remaining_q <= cmd_len_i;
      end else if (ar_hs) begin
        addr_q      <= addr_q + 32'({beats_q, 2'b00});
        remaining_q <= remaining_q - 24'(beats_q);
      end
      if (issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_q;
        arlen_q   <= 8'(beats_c - 9'd1);
        beats_q   <= beats_c;
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
      alloc_q <= alloc_q + (ar_hs ? CW'(beats_q) : '0)
                         - (pop ? CW'(1) : '0);
      if (cmd_acc)  out_cnt_q <= cmd_len_i;
      else if (pop) out_cnt_q <= out_cnt_q - 24'd1;
      if (cmd_acc) error_q <= 1'b0;
      else if (r_wr && outport_rresp_i != RESP_OKAY) error_q <= 1'b1;
    end
  end

  axi4_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (r_wr),
    .wr_data_i (outport_rdata_i),
    .rd_en_i   (pop),
    .rd_data_o (outport_data_o),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign fifo_full         = (fifo_cnt == CW'(FIFO_DEPTH));
  assign cmd_ready_o       = (state_q == ST_IDLE);
  assign busy_o            = (state_q != ST_IDLE);
  assign error_o           = error_q;
  assign outport_valid_o   = !fifo_empty;
  assign outport_last_o    = outport_valid_o && (out_cnt_q == 24'd1);
  assign outport_arvalid_o = arvalid_q;
  assign outport_araddr_o  = araddr_q;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = arlen_q;
  assign outport_arburst_o = BURST_INCR;
  assign outport_rready_o  = (state_q != ST_IDLE);
  assign unused_ok = ^{outport_rid_i, outport_rlast_i, cmd_addr_i[1:0]};

  // Conditions that credit and caller alignment rule out
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(r_wr && fifo_full));
      assert (!(state_q == ST_IDLE && outport_rvalid_i));
      assert (!(issue && page_cross));
    end
  end

endmodule

// File: tb/tb_axi4_burst_fetch.sv
// tb_axi4_burst_fetch: scoreboard bench with AXI slave and consumer model.
// Covers basic fetch, 4KB split, back-pressure, error, len=0, reset.
module tb_axi4_burst_fetch;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [23:0] cmd_len_i = '0;
  logic        cmd_ready_o, busy_o, error_o;
  logic        outport_valid_o, outport_last_o;
  logic [31:0] outport_data_o;
  logic        outport_ready_i = 1'b0;
  logic        outport_arvalid_o;
  logic [31:0] outport_araddr_o;
  logic [3:0]  outport_arid_o;
  logic [7:0]  outport_arlen_o;
  logic [1:0]  outport_arburst_o;
  logic        outport_arready_i = 1'b0;
  logic        outport_rvalid_i = 1'b0;
  logic [31:0] outport_rdata_i = '0;
  logic [1:0]  outport_rresp_i = '0;
  logic        outport_rready_o;

  axi4_burst_fetch #(
    .AXI_ID     (4'h3),
    .BURST_LEN  (16),
    .FIFO_DEPTH (64)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_addr_i        (cmd_addr_i),
    .cmd_len_i         (cmd_len_i),
    .cmd_ready_o       (cmd_ready_o),
    .busy_o            (busy_o),
    .error_o           (error_o),
    .outport_valid_o   (outport_valid_o),
    .outport_data_o    (outport_data_o),
    .outport_last_o    (outport_last_o),
    .outport_ready_i   (outport_ready_i),
    .outport_arvalid_o (outport_arvalid_o),
    .outport_araddr_o  (outport_araddr_o),
    .outport_arid_o    (outport_arid_o),
    .outport_arlen_o   (outport_arlen_o),
    .outport_arburst_o (outport_arburst_o),
    .outport_arready_i (outport_arready_i),
    .outport_rvalid_i  (outport_rvalid_i),
    .outport_rdata_i   (outport_rdata_i),
    .outport_rresp_i   (outport_rresp_i),
    .outport_rid_i     (4'h3),
    .outport_rlast_i   (1'b0),
    .outport_rready_o  (outport_rready_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_w[$];
  logic [39:0] exp_ar[$];
  logic [31:0] s_addr[$];
  int          s_left[$];
  int          ar_count = 0;
  bit          stall_seen = 0;
  bit          flush_req = 0;
  bit          chk_idle_next = 0;
  int          cons_mode = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input logic [31:0] a, input int len);
    for (int i = 0; i < len; i++)
      exp_w.push_back({i == len - 1, a + 32'(4 * i)});
  endtask

  task automatic push_ar(input logic [31:0] a, input int arlen);
    exp_ar.push_back({8'(arlen), a});
  endtask

  // Reference burst split: 16-beat cap, optional page cut
  task automatic push_ars(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int r, b;
    a = a0;
    r = len;
    while (r > 0) begin
      b = (r < 16) ? r : 16;
`ifdef AXI_FETCH_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / 4 < b) b = (4096 - int'(a[11:0])) / 4;
`endif
      push_ar(a, b - 1);
      a = a + 32'(4 * b);
      r = r - b;
    end
  endtask

  always @(posedge clk) if (rst_i) flush_req = 1;

  // Slave, consumer and output monitor; handshakes land on next posedge
  always @(negedge clk) begin
    if (flush_req) begin
      flush_req = 0;
      chk_idle_next = 0;
      s_addr.delete();
      s_left.delete();
    end
    if (chk_idle_next) begin
      chk_idle_next = 0;
      chk("busy_after_last", busy_o, 0);
      chk("ready_after_last", cmd_ready_o, 1);
    end
    outport_arready_i = ($urandom_range(0, 3) != 0);
    outport_ready_i = (cons_mode == 0) ? 1'b1 :
                      (cons_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    if (s_addr.size() != 0 && $urandom_range(0, 3) != 0) begin
      outport_rvalid_i = 1'b1;
      outport_rdata_i  = s_addr[0];
      outport_rresp_i  = (s_addr[0] == err_addr) ? 2'b10 : 2'b00;
    end else begin
      outport_rvalid_i = 1'b0;
      outport_rdata_i  = '0;
      outport_rresp_i  = '0;
    end
    if (s_addr.size() != 0 && !outport_rready_o) stall_seen = 1;
    if (outport_rvalid_i && outport_rready_o) begin
      s_addr[0] = s_addr[0] + 32'd4;
      s_left[0] = s_left[0] - 1;
      if (s_left[0] == 0) begin
        void'(s_addr.pop_front());
        void'(s_left.pop_front());
      end
    end
    if (outport_arvalid_o && outport_arready_i) begin
      logic [39:0] e;
      ar_count++;
      if (exp_ar.size() == 0) begin
        chk("ar_unexpected", outport_araddr_o, 32'hFFFF_FFFF);
      end else begin
        e = exp_ar.pop_front();
        chk("araddr", outport_araddr_o, e[31:0]);
        chk("arlen", {24'd0, outport_arlen_o}, {24'd0, e[39:32]});
      end
      s_addr.push_back(outport_araddr_o);
      s_left.push_back(int'(outport_arlen_o) + 1);
    end
    if (outport_valid_o && outport_ready_i) begin
      logic [32:0] w;
      if (exp_w.size() == 0) begin
        chk("word_unexpected", outport_data_o, 32'hFFFF_FFFF);
      end else begin
        w = exp_w.pop_front();
        chk("data", outport_data_o, w[31:0]);
        chk("last", {31'd0, outport_last_o}, {31'd0, w[32]});
        if (w[32]) chk_idle_next = 1;
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int len);
    int n;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = 24'(len);
    n = 0;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cmd_timeout", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy_o || exp_w.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      chk("timeout_busy", busy_o, 0);
      chk("timeout_words", exp_w.size(), 0);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_error"}, error_o, 0);
    chk({tag, "_valid"}, outport_valid_o, 0);
    chk({tag, "_last"}, outport_last_o, 0);
    chk({tag, "_arvalid"}, outport_arvalid_o, 0);
    chk({tag, "_araddr"}, outport_araddr_o, 0);
    chk({tag, "_arlen"}, {24'd0, outport_arlen_o}, 0);
    chk({tag, "_arid"}, {28'd0, outport_arid_o}, 3);
    chk({tag, "_arburst"}, {30'd0, outport_arburst_o}, 1);
    chk({tag, "_rready"}, outport_rready_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_i = 1'b0;

    // Basic fetch: three bursts, 40 words in order
    cons_mode = 0;
    push_words(32'h1000, 40);
    push_ar(32'h1000, 15);
    push_ar(32'h1040, 15);
    push_ar(32'h1080, 7);
    base = ar_count;
    send_cmd(32'h1000, 40);
    wait_done(2000);
    chk("basic_ar_count", ar_count - base, 3);
    chk("basic_ar_left", exp_ar.size(), 0);

`ifdef AXI_FETCH_4K_SPLIT_EN
    // Page split at 0x1000
    push_words(32'h0FF8, 8);
    push_ar(32'h0FF8, 1);
    push_ar(32'h1000, 5);
    base = ar_count;
    send_cmd(32'h0FF8, 8);
    wait_done(1000);
    chk("split_ar_count", ar_count - base, 2);
`endif

    // SLVERR on beat 3, data still delivered, sticky error
    cons_mode = 2;
    err_addr = 32'h3008;
    push_words(32'h3000, 4);
    push_ar(32'h3000, 3);
    send_cmd(32'h3000, 4);
    wait_done(1000);
    chk("error_set", error_o, 1);
    repeat (5) @(negedge clk);
    chk("error_sticky", error_o, 1);
    err_addr = 32'hFFFF_FFFF;

    // len=0: accepted, no AR, clears error, stays idle
    base = ar_count;
    send_cmd(32'h0100, 0);
    chk("len0_error_clr", error_o, 0);
    chk("len0_busy", busy_o, 0);
    chk("len0_cmd_ready", cmd_ready_o, 1);
    chk("len0_valid", outport_valid_o, 0);
    repeat (4) @(negedge clk);
    chk("len0_no_ar", ar_count - base, 0);

    // Back-pressure: credit stops issue at 64 words
    cons_mode = 1;
    stall_seen = 0;
    push_words(32'h2000, 200);
    push_ars(32'h2000, 200);
    base = ar_count;
    send_cmd(32'h2000, 200);
    repeat (300) @(negedge clk);
    chk("bp_ar_count", ar_count - base, 4);
    chk("bp_arvalid", outport_arvalid_o, 0);
    chk("bp_valid", outport_valid_o, 1);
    cons_mode = 2;
    wait_done(5000);
    chk("bp_total_ar", ar_count - base, 13);
    chk("no_r_stall", stall_seen, 0);

    // Reset after the 2nd AR handshake
    cons_mode = 1;
    push_words(32'h4000, 64);
    push_ars(32'h4000, 64);
    base = ar_count;
    send_cmd(32'h4000, 64);
    for (int i = 0; i < 500 && ar_count - base < 2; i++)
      @(negedge clk);
    chk("mid_ar_seen", ar_count - base, 2);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_w.delete();
    exp_ar.delete();
    chk_reset_vals("mid");
    cons_mode = 0;
    push_words(32'h5000, 4);
    push_ar(32'h5000, 3);
    send_cmd(32'h5000, 4);
    wait_done(1000);
    chk("post_rst_ar_left", exp_ar.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_burst_fetch.md
Name: axi4_burst_fetch

Overview:
- AXI4 read initiator (master) that fetches a contiguous DDR region and presents it as a 32-bit valid/ready word stream.
- Sits between the DDR AXI4 slave port (ui_clk domain) and the video/audio consumers.
- Issues INCR read bursts and limits outstanding data by FIFO credit, so R is never back-pressured.

Parameters:
- AXI_ID, 0, constant arid value (4 bits).
- BURST_LEN, 16, maximum beats per burst; power of 2, 1..256.
- FIFO_DEPTH, 64, output FIFO words; power of 2, >= BURST_LEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  fetch request valid.
- cmd_addr_i  in  32  byte start address; bits [1:0] ignored, treated as 0.
- cmd_len_i  in  24  length in 32-bit words.
- cmd_ready_o  out  1  request accepted (high only in IDLE).
- busy_o  out  1  high when not IDLE.
- error_o  out  1  sticky: any non-OKAY rresp since last command accept.
- outport_valid_o  out  1  stream word valid.
- outport_data_o  out  32  stream word.
- outport_last_o  out  1  final word of command.
- outport_ready_i  in  1  consumer accept.
- outport_arvalid_o  out  1  AXI AR valid.
- outport_araddr_o  out  32  AXI AR address.
- outport_arid_o  out  4  AXI AR id (=AXI_ID).
- outport_arlen_o  out  8  beats-1.
- outport_arburst_o  out  2  fixed 2'b01 (INCR).
- outport_arready_i  in  1  AXI AR ready.
- outport_rvalid_i  in  1  AXI R valid.
- outport_rdata_i  in  32  AXI R data.
- outport_rresp_i  in  2  AXI R response.
- outport_rid_i  in  4  AXI R id (ignored).
- outport_rlast_i  in  1  AXI R last (ignored; beats are counted).
- outport_rready_o  out  1  AXI R ready.

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o=1, outport_arburst_o=2'b01, outport_arid_o=AXI_ID. FIFO is emptied and all counters are cleared.
- Reset mid-operation abandons the command. The system guarantees the AXI slave is reset by the same event.
- Word size is fixed at 4 bytes (arsize=3'b010 at the slave).
- State machine IDLE, REQ, DRAIN.
- IDLE: cmd_ready_o=1. On cmd_valid_i:
  - latch addr (with [1:0]=0) and remaining=len; out_cnt=len; clear error_o.
  - If len=0, stay in IDLE; no AR is issued and no output word is produced. Otherwise go to REQ.
- REQ, burst size:
  - beats = min(BURST_LEN, remaining, words to next 4KB boundary when the optional feature is enabled).
  - beats is computed combinationally when arvalid rises and held stable, together with araddr and arlen, until arready. arvalid never drops without a handshake.
- REQ, issue condition: arvalid asserts only when (FIFO_DEPTH - allocated) >= beats. allocated = FIFO occupancy + beats in flight.
- REQ, on AR handshake:
  - addr += beats*4 (32-bit wrap).
  - remaining -= beats; allocated += beats.
  - If remaining becomes 0, go to DRAIN; else re-evaluate the next burst (earliest arvalid is the next cycle).
- outport_rready_o = 1 in REQ and DRAIN. Credit guarantees FIFO space, so R is never stalled.
- Each R beat writes the FIFO. If rresp != 2'b00, error_o is set and the data is still forwarded.
- Output side:
  - FIFO is first-word-fall-through: outport_valid_o = !empty.
  - On a pop, allocated -= 1 and out_cnt -= 1.
  - outport_last_o = valid && out_cnt==1.
- DRAIN: return to IDLE in the cycle after the pop with out_cnt==1. cmd_ready_o is high from that cycle.
- Simultaneous AR handshake and pop in one cycle: allocated += beats-1.
- Latency: first AR is at the earliest the cycle after command accept. The first output word is valid the cycle after its R beat is written.
- FIFO full is unreachable by construction; an assertion checks that a write never occurs while full.
- A stray R beat in IDLE is ignored (rready_o=0); an assertion flags it.

Optional Feature:
- Macro AXI_FETCH_4K_SPLIT_EN.
- Defined: bursts are truncated so no burst crosses a 4KB address boundary. Words to boundary = (4096 - addr[11:0])/4.
- Undefined: the 4KB term is omitted. The caller guarantees alignment, and an assertion flags a crossing burst.

Decomposition:
- Shared package (axi4_defs): AXI burst encodings (INCR=2'b01), response codes (OKAY/EXOKAY/SLVERR/DECERR), SIZE_4B=3'b010, 4KB page constant.
- Sub-module axi4_fetch_fifo: synchronous first-word-fall-through FIFO, parameterised WIDTH=32 and DEPTH, with count output.

Test Plan:
- Basic fetch: addr=0x1000, len=40, BURST_LEN=16, consumer always ready, slave returns incrementing data.
  - Expect ARs at 0x1000/arlen 15, 0x1040/arlen 15, 0x1080/arlen 7.
  - 40 words in order, outport_last_o only on word 40, busy_o low the following cycle.
- 4K split (macro on): addr=0x0FF8, len=8.
  - Expect AR 0x0FF8/arlen 1, then AR 0x1000/arlen 5.
  - With the macro off, a single AR arlen 7 and an assertion hit.
- Back-pressure: FIFO_DEPTH=64, outport_ready_i=0, len=200.
  - Exactly 4 ARs of 16 accepted, then arvalid stays low.
  - Releasing ready resumes issue; no R stall ever occurs (rready_o=1 throughout).
- Error: slave returns SLVERR on beat 3 of a len=4 fetch.
  - All 4 words delivered and error_o=1 until the next command accept, which clears it.
- len=0 command: cmd accepted, no AR, no output, busy_o stays 0, next command accepted the following cycle.
- Reset mid-burst: assert rst_i for 1 cycle after the 2nd AR handshake.
  - All outputs return to reset values; FIFO is empty; a new len=4 fetch then completes correctly.
